swbut_debounce: RTL and testbench

Input conditioner for the switch/button word that feeds the collatz swbut top. It takes 16 raw, asynchronous board lines (switches and buttons) and synchronises each bit. Each bit is debounced independently with its own counter. Outputs are the clean stable word plus one-cycle rise/fall strobes and a "changed" strobe, so the downstream compute block sees only settled values and single-cycle button events.

---
 rtl/swbut_debounce_pkg.sv | 13 +
 rtl/swbut_debounce_bit.sv | 50 +++++
 rtl/swbut_debounce.sv | 34 +++
 tb/tb_swbut_debounce.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/swbut_debounce_pkg.sv
// Shared definitions for the switch/button input conditioner: board bit map,
// default debounce depth and the counter-width helper.
package swbut_debounce_pkg;

  localparam int BTN_BIT          = 15;
  localparam int SW_BIT           = 0;
  localparam int DEFAULT_DEBOUNCE = 50000;

  function automatic int cnt_width(input int debounce);
    return $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/swbut_debounce_bit.sv
// Single-line conditioner: 2-flop synchroniser, debounce counter, stable flop, edge strobes.
// Latency: a level first sampled at edge k is accepted at edge k+1+DEBOUNCE; no backpressure.
module swbut_debounce_bit
  import swbut_debounce_pkg::*;
#(
  parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      out  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      // Any return to the stable level discards the partial count.
      if (s2 == out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        out  <= s2;
        cnt  <= '0;
        rise <= s2;
        fall <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/swbut_debounce.sv
// Debounces WIDTH independent switch/button lines into a stable word plus rise/fall/changed strobes.
// Latency: DEBOUNCE+2 edges from first sample to visible output; no backpressure.
module swbut_debounce
  import swbut_debounce_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    swbut_debounce_bit #(
      .DEBOUNCE(DEBOUNCE)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .raw (raw[i]),
      .out (out[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end

  // Strobes are already registered, so this stays a clean one-cycle pulse.
  assign changed = |(rise | fall);

endmodule

// File: tb/tb_swbut_debounce.sv
// Self-checking bench for swbut_debounce with DEBOUNCE=4: vector table, hand sequences, random vs model.
module tb_swbut_debounce;

  localparam int W = 16;
  localparam int D = 4;

  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } exp_t;

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw = '0;
  logic [W-1:0] d_out, d_rise, d_fall;
  logic         d_chg;

  swbut_debounce #(.WIDTH(W), .DEBOUNCE(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .raw    (raw),
    .out    (d_out),
    .rise   (d_rise),
    .fall   (d_fall),
    .changed(d_chg)
  );

  always #1 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  // Reference model state
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_out = '0;
  int           m_cnt[W];

  function automatic exp_t mk(input logic [W-1:0] o, input logic [W-1:0] r,
                              input logic [W-1:0] f, input logic c);
    exp_t e;
    e.out = o; e.rise = r; e.fall = f; e.chg = c;
    return e;
  endfunction

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  function automatic exp_t model_edge(input logic r, input logic [W-1:0] rv);
    logic [W-1:0] ri, fi;
    ri = '0; fi = '0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_out = '0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_out[i]) begin
          m_cnt[i] = 0;
        end else if (m_cnt[i] == D - 1) begin
          m_out[i] = m_s2[i];
          m_cnt[i] = 0;
          if (m_s2[i]) ri[i] = 1'b1; else fi[i] = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = rv;
    end
    return mk(m_out, ri, fi, |(ri | fi));
  endfunction

  // One clock edge: drive inputs, queue the expectation, then compare after the edge.
  task automatic step(input string name, input logic r, input logic [W-1:0] rv,
                      input logic use_hand, input exp_t hand);
    exp_t me, e;
    rst = r;
    raw = rv;
    me = model_edge(r, rv);
    exp_q.push_back(use_hand ? hand : me);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({name, ".out"},  d_out,  e.out);
    chk({name, ".rise"}, d_rise, e.rise);
    chk({name, ".fall"}, d_fall, e.fall);
    chk({name, ".chg"},  {15'd0, d_chg}, {15'd0, e.chg});
  endtask

  vec_t tbl[10];

  initial begin
    logic [W-1:0] rv;
    logic         rr;
    for (int i = 0; i < W; i++) m_cnt[i] = 0;

    // Reset, then 16'h8001 held: accepted at edge k+5 (table index 7).
    tbl[0] = '{1'b1, 16'h0000, mk(16'h0000, 16'h0000, 16'h0000, 1'b0)};
    tbl[1] = '{1'b1, 16'h8001, mk(16'h0000, 16'h0000, 16'h0000, 1'b0)};
    for (int i = 2; i <= 6; i++)
      tbl[i] = '{1'b0, 16'h8001, mk(16'h0000, 16'h0000, 16'h0000, 1'b0)};
    tbl[7] = '{1'b0, 16'h8001, mk(16'h8001, 16'h8001, 16'h0000, 1'b1)};
    tbl[8] = '{1'b0, 16'h8001, mk(16'h8001, 16'h0000, 16'h0000, 1'b0)};
    tbl[9] = '{1'b0, 16'h8001, mk(16'h8001, 16'h0000, 16'h0000, 1'b0)};

    @(negedge clk);
    foreach (tbl[i]) step($sformatf("press[%0d]", i), tbl[i].rst, tbl[i].raw, 1'b1, tbl[i].e);

    // Two 3-cycle low glitches on the button: never accepted.
    for (int i = 0; i < 15; i++) begin
      rv = (i < 3 || (i >= 6 && i < 9)) ? 16'h0001 : 16'h8001;
      step($sformatf("glitch[%0d]", i), 1'b0, rv, 1'b1, mk(16'h8001, 16'h0000, 16'h0000, 1'b0));
    end

    // Button release: fall on bit 15 at edge k+5.
    for (int i = 0; i < 7; i++) begin
      if (i < 5)       step($sformatf("rel[%0d]", i), 1'b0, 16'h0001, 1'b1, mk(16'h8001, 16'h0000, 16'h0000, 1'b0));
      else if (i == 5) step($sformatf("rel[%0d]", i), 1'b0, 16'h0001, 1'b1, mk(16'h0001, 16'h0000, 16'h8000, 1'b1));
      else             step($sformatf("rel[%0d]", i), 1'b0, 16'h0001, 1'b1, mk(16'h0001, 16'h0000, 16'h0000, 1'b0));
    end

    // All-ones with a reset pulse mid-count: full latency restarts after reset.
    for (int i = 0; i < 3; i++)
      step($sformatf("rstmid[%0d]", i), 1'b0, 16'hFFFF, 1'b1, mk(16'h0001, 16'h0000, 16'h0000, 1'b0));
    step("rstmid.rst", 1'b1, 16'hFFFF, 1'b1, mk(16'h0000, 16'h0000, 16'h0000, 1'b0));
    for (int i = 0; i < 7; i++) begin
      if (i < 5)       step($sformatf("rstpost[%0d]", i), 1'b0, 16'hFFFF, 1'b1, mk(16'h0000, 16'h0000, 16'h0000, 1'b0));
      else if (i == 5) step($sformatf("rstpost[%0d]", i), 1'b0, 16'hFFFF, 1'b1, mk(16'hFFFF, 16'hFFFF, 16'h0000, 1'b1));
      else             step($sformatf("rstpost[%0d]", i), 1'b0, 16'hFFFF, 1'b1, mk(16'hFFFF, 16'h0000, 16'h0000, 1'b0));
    end

    // Settle to zero using the model.
    for (int i = 0; i < 8; i++) step($sformatf("clear[%0d]", i), 1'b0, 16'h0000, 1'b0, '0);

    // Bits 0 and 3 together, bit 7 two edges later: two separate changed pulses.
    for (int i = 0; i < 9; i++) begin
      rv = (i < 2) ? 16'h0009 : 16'h0089;
      case (i)
        5:       step($sformatf("multi[%0d]", i), 1'b0, rv, 1'b1, mk(16'h0009, 16'h0009, 16'h0000, 1'b1));
        6:       step($sformatf("multi[%0d]", i), 1'b0, rv, 1'b1, mk(16'h0009, 16'h0000, 16'h0000, 1'b0));
        7:       step($sformatf("multi[%0d]", i), 1'b0, rv, 1'b1, mk(16'h0089, 16'h0080, 16'h0000, 1'b1));
        8:       step($sformatf("multi[%0d]", i), 1'b0, rv, 1'b1, mk(16'h0089, 16'h0000, 16'h0000, 1'b0));
        default: step($sformatf("multi[%0d]", i), 1'b0, rv, 1'b1, mk(16'h0000, 16'h0000, 16'h0000, 1'b0));
      endcase
    end

    // Random bounce against the reference model.
    rv = 16'h0089;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) rv = 16'($urandom);
      else if ($urandom_range(0, 3) == 0) rv = rv ^ (16'd1 << $urandom_range(0, W - 1));
      rr = ($urandom_range(0, 199) == 0);
      step($sformatf("rand[%0d]", i), rr, rv, 1'b0, '0);
      chk($sformatf("rand[%0d].rise&fall", i), d_rise & d_fall, 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
